buf_fifo: RTL and testbench

BUF_FIFO -- requirements
Module: buf_fifo

---
 rtl/buf_defs.sv | 16 +
 rtl/buf_ram.sv | 26 ++
 rtl/buf_fifo.sv | 85 ++++++++
 tb/tb_buf_fifo.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/buf_defs.sv
// Shared constants for buffer blocks: default geometry and a constant-time log2
// used to size pointers from a depth parameter.
package buf_defs;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 4;

   // Ceiling log2; exact for the power-of-two depths these buffers use.
   function automatic int log2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/buf_ram.sv
// Register-array storage for buf_fifo: one synchronous write port, one
// asynchronous read port, contents never reset.
module buf_ram
   import buf_defs::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = log2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/buf_fifo.sv
// Synchronous FIFO with valid/ready on both sides; control lives here, words
// live in buf_ram. Flags are decoded from registered occupancy only.
module buf_fifo
   import buf_defs::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = log2(DEPTH)
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             FLUSH,
   input  logic [WIDTH-1:0] I,
   input  logic             I_VALID,
   output logic             I_READY,
   output logic [WIDTH-1:0] O,
   output logic             O_VALID,
   input  logic             O_READY,
   output logic [AW:0]      COUNT,
   output logic             FULL,
   output logic             EMPTY
);

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          push, pop, ram_we;

   // Handshake: a word moves on a rising edge where valid && ready on that side.
   // I_READY also rises when the consumer drains in the same cycle, so a full
   // buffer can stream at one word per cycle.
   assign FULL    = (count_q == DEPTH_C);
   assign EMPTY   = (count_q == '0);
   assign O_VALID = !EMPTY;
   assign I_READY = !FULL || O_READY;
   assign COUNT   = count_q;

   assign push   = I_VALID && I_READY;
   assign pop    = O_VALID && O_READY;
   assign ram_we = push && !FLUSH;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (FLUSH) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         if (push && !pop)      count_d = count_q + (AW+1)'(1);
         else if (pop && !push) count_d = count_q - (AW+1)'(1);
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   buf_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk_i   (CLK),
      .we_i    (ram_we),
      .waddr_i (wr_ptr_q),
      .wdata_i (I),
      .raddr_i (rd_ptr_q),
      .rdata_o (O)
   );

endmodule

// File: tb/tb_buf_fifo.sv
// Bench for buf_fifo: a small 8x4 instance for directed scenarios and a 32x16
// instance for long random traffic, both checked against queue models.
module tb_buf_fifo;

   logic CLK = 1'b0;
   logic RESET;
   always #5 CLK = ~CLK;

   logic        a_fl, a_iv, a_or, a_ir, a_ov, a_full, a_empty;
   logic [7:0]  a_i, a_o;
   logic [2:0]  a_cnt;
   logic        b_fl, b_iv, b_or, b_ir, b_ov, b_full, b_empty;
   logic [31:0] b_i, b_o;
   logic [4:0]  b_cnt;

   logic [31:0] aq[$];
   logic [31:0] bq[$];
   logic        a_last_push = 1'b0;
   logic        b_last_push = 1'b0;
   int          n_chk = 0;
   int          n_fail = 0;
   int          bias_in, bias_out;
   logic [7:0]  drain [4];

   buf_fifo #(.WIDTH(8), .DEPTH(4)) dut_a (
      .CLK(CLK), .RESET(RESET), .FLUSH(a_fl),
      .I(a_i), .I_VALID(a_iv), .I_READY(a_ir),
      .O(a_o), .O_VALID(a_ov), .O_READY(a_or),
      .COUNT(a_cnt), .FULL(a_full), .EMPTY(a_empty)
   );

   buf_fifo #(.WIDTH(32), .DEPTH(16)) dut_b (
      .CLK(CLK), .RESET(RESET), .FLUSH(b_fl),
      .I(b_i), .I_VALID(b_iv), .I_READY(b_ir),
      .O(b_o), .O_VALID(b_ov), .O_READY(b_or),
      .COUNT(b_cnt), .FULL(b_full), .EMPTY(b_empty)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   // Reference model: ordered queues; a push is accepted when there is room
   // or the consumer is taking a word in the same cycle; flush empties.
   always @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         aq.delete();
         bq.delete();
         a_last_push = 1'b0;
         b_last_push = 1'b0;
      end else begin
         a_last_push = !a_fl && a_iv && (aq.size() < 4 || a_or);
         if (a_fl) aq.delete();
         else begin
            if (aq.size() != 0 && a_or) void'(aq.pop_front());
            if (a_last_push) aq.push_back(32'(a_i));
         end
         b_last_push = !b_fl && b_iv && (bq.size() < 16 || b_or);
         if (b_fl) bq.delete();
         else begin
            if (bq.size() != 0 && b_or) void'(bq.pop_front());
            if (b_last_push) bq.push_back(b_i);
         end
      end
   end

   always @(negedge CLK) begin
      if (!RESET) begin
         chk("a_count",   64'(a_cnt),   64'(aq.size()));
         chk("a_empty",   64'(a_empty), 64'(aq.size() == 0));
         chk("a_full",    64'(a_full),  64'(aq.size() == 4));
         chk("a_o_valid", 64'(a_ov),    64'(aq.size() != 0));
         chk("a_i_ready", 64'(a_ir),    64'(aq.size() < 4 || a_or));
         if (aq.size() != 0) chk("a_o", 64'(a_o), 64'(aq[0]));
         chk("b_count",   64'(b_cnt),   64'(bq.size()));
         chk("b_empty",   64'(b_empty), 64'(bq.size() == 0));
         chk("b_full",    64'(b_full),  64'(bq.size() == 16));
         chk("b_o_valid", 64'(b_ov),    64'(bq.size() != 0));
         chk("b_i_ready", 64'(b_ir),    64'(bq.size() < 16 || b_or));
         chk("b_count_le_16", 64'(b_cnt <= 5'd16), 64'(1));
         if (bq.size() != 0) chk("b_o", 64'(b_o), 64'(bq[0]));
      end
   end

   initial begin
      RESET = 1'b1;
      a_fl = 1'b0; a_iv = 1'b0; a_or = 1'b0; a_i = '0;
      b_fl = 1'b0; b_iv = 1'b0; b_or = 1'b0; b_i = '0;
      drain = '{8'h22, 8'h33, 8'h44, 8'h55};
      repeat (2) @(posedge CLK);
      #2 RESET = 1'b0;
      #1;
      chk("rst_count",   64'(a_cnt),   64'(0));
      chk("rst_empty",   64'(a_empty), 64'(1));
      chk("rst_full",    64'(a_full),  64'(0));
      chk("rst_o_valid", 64'(a_ov),    64'(0));
      chk("rst_i_ready", 64'(a_ir),    64'(1));

      // Fill to full with the consumer stalled.
      for (int k = 0; k < 4; k++) begin
         a_iv = 1'b1;
         a_i  = 8'(8'h11 * (k + 1));
         tick();
         if (k == 0) begin
            chk("latency_o_valid", 64'(a_ov), 64'(1));
            chk("latency_o",       64'(a_o),  64'(8'h11));
         end
      end
      a_iv = 1'b0;
      #1;
      chk("fill_count",   64'(a_cnt), 64'(4));
      chk("fill_full",    64'(a_full), 64'(1));
      chk("fill_i_ready", 64'(a_ir),  64'(0));
      chk("fill_o",       64'(a_o),   64'(8'h11));

      // Simultaneous push and pop while full.
      a_iv = 1'b1; a_i = 8'h55; a_or = 1'b1;
      #1 chk("full_pp_i_ready", 64'(a_ir), 64'(1));
      tick();
      a_iv = 1'b0;
      #1;
      chk("full_pp_count", 64'(a_cnt), 64'(4));
      chk("full_pp_full",  64'(a_full), 64'(1));
      chk("full_pp_o",     64'(a_o),   64'(8'h22));
      for (int k = 0; k < 4; k++) begin
         chk("drain_o", 64'(a_o), 64'(drain[k]));
         tick();
      end
      a_or = 1'b0;
      #1 chk("drain_empty", 64'(a_empty), 64'(1));

      // Streaming through the wrap: each word popped the cycle after its push.
      for (int k = 1; k <= 11; k++) begin
         a_iv = (k <= 10);
         a_i  = 8'(k);
         a_or = (k > 1);
         #1;
         if (k > 1) begin
            chk("stream_o",     64'(a_o),   64'(k - 1));
            chk("stream_count", 64'(a_cnt), 64'(1));
         end
         tick();
      end
      a_iv = 1'b0; a_or = 1'b0;
      #1 chk("stream_end_count", 64'(a_cnt), 64'(0));

      // Flush beats a concurrent push and pop.
      for (int k = 0; k < 3; k++) begin
         a_iv = 1'b1;
         a_i  = 8'(8'hA0 + k);
         tick();
      end
      a_iv = 1'b0;
      #1 chk("pre_flush_count", 64'(a_cnt), 64'(3));
      a_fl = 1'b1; a_iv = 1'b1; a_i = 8'hEE; a_or = 1'b1;
      tick();
      a_fl = 1'b0; a_iv = 1'b0; a_or = 1'b0;
      #1;
      chk("flush_count",   64'(a_cnt),   64'(0));
      chk("flush_empty",   64'(a_empty), 64'(1));
      chk("flush_o_valid", 64'(a_ov),    64'(0));
      a_iv = 1'b1; a_i = 8'h77;
      tick();
      a_i = 8'h88;
      #1;
      chk("post_flush_o",     64'(a_o),   64'(8'h77));
      chk("post_flush_count", 64'(a_cnt), 64'(1));
      tick();
      a_iv = 1'b0;
      #1 chk("pre_reset_count", 64'(a_cnt), 64'(2));

      // Asynchronous reset between edges.
      RESET = 1'b1;
      #1;
      chk("async_rst_count", 64'(a_cnt),   64'(0));
      chk("async_rst_empty", 64'(a_empty), 64'(1));
      chk("async_rst_full",  64'(a_full),  64'(0));
      tick();
      RESET = 1'b0;
      a_iv = 1'b1; a_i = 8'h99;
      tick();
      a_iv = 1'b0;
      #1;
      chk("post_rst_o",     64'(a_o),   64'(8'h99));
      chk("post_rst_count", 64'(a_cnt), 64'(1));
      a_or = 1'b1;
      tick();
      a_or = 1'b0;
      #1 chk("post_rst_empty", 64'(a_empty), 64'(1));

      // Random traffic on both instances; producers hold a word until taken.
      bias_in = 5; bias_out = 5;
      for (int c = 0; c < 10000; c++) begin
         if (c % 1000 == 0) begin
            bias_in  = $urandom_range(1, 9);
            bias_out = $urandom_range(1, 9);
         end
         if (!a_iv || a_last_push) begin
            a_iv = ($urandom_range(0, 9) < bias_in);
            a_i  = 8'($urandom);
         end
         if (!b_iv || b_last_push) begin
            b_iv = ($urandom_range(0, 9) < bias_in);
            b_i  = $urandom;
         end
         a_or = ($urandom_range(0, 9) < bias_out);
         b_or = ($urandom_range(0, 9) < bias_out);
         a_fl = ($urandom_range(0, 299) == 0);
         b_fl = ($urandom_range(0, 499) == 0);
         tick();
      end
      a_iv = 1'b0; a_or = 1'b0; a_fl = 1'b0;
      b_iv = 1'b0; b_or = 1'b0; b_fl = 1'b0;
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
